// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: FIFO prefill, start pulse and per-strobe sample feed for the folded FIR; FIR_FEEDER_UNDERRUN_CNT_EN adds underrun_cnt
module fir_sample_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 8,
  parameter int START_LEVEL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    clr,
  output logic                    fir_en,
  input  logic                    fir_sample_in,
  output logic [DATA_WIDTH-1:0]   fir_din,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    underrun
`ifdef FIR_FEEDER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]             underrun_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [1:0] FILL = 2'd0, START = 2'd1, RUN = 2'd2;
  logic [LW-1:0]         level_q, level_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  underrun_q, underrun_d;
  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  push, pop, uf;
  always_comb begin
    s_ready    = level_q != LW'(DEPTH);
    push       = s_valid && s_ready;
    pop        = fir_sample_in && state_q != FILL && level_q != '0;
    uf         = fir_sample_in && state_q != FILL && level_q == '0;
    level_d    = clr ? '0 : level_q + LW'(push) - LW'(pop);
    wr_ptr_d   = clr ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d   = clr ? '0 : rd_ptr_q + PW'(pop);
    underrun_d = !clr && (underrun_q || uf);
    state_d    = state_q == FILL ? (level_d >= LW'(START_LEVEL) ? START : FILL) : RUN;
    mem_d      = mem_q;
    if (push && !clr) mem_d[wr_ptr_q] = s_data;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      underrun_q <= 1'b0;
      state_q    <= FILL;
    end else begin
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      underrun_q <= underrun_d;
      state_q    <= state_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign fir_en   = state_q == START;
  assign fir_din  = level_q != '0 ? mem_q[rd_ptr_q] : '0;
  assign level    = level_q;
  assign underrun = underrun_q;
`ifdef FIR_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? 16'd0 : (uf && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= 16'd0;
    else cnt_q <= cnt_d;
  end
  assign underrun_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: randomized stimulus against a queue-based reference model of the sample feeder
module tb_fir_sample_feeder;
  localparam int DEPTH = 8, SL = 4;
  logic        clk, rst, s_valid, s_ready, clr, fir_en, fir_sample_in, underrun;
  logic [15:0] s_data, fir_din;
  logic [3:0]  level;
`ifdef FIR_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif
  int checks = 0, failures = 0;
  fir_sample_feeder dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .clr(clr), .fir_en(fir_en), .fir_sample_in(fir_sample_in), .fir_din(fir_din),
    .level(level), .underrun(underrun)
`ifdef FIR_FEEDER_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  logic [15:0] q[$];
  bit          mv = 0, uf_m = 0;
  int          ph = 0, sz;
  logic [15:0] cnt_m = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (mv && rst) begin
      sz = q.size();
      chk("level", 32'(level), 32'(sz));
      chk("s_ready", 32'(s_ready), 32'(sz != DEPTH));
      chk("fir_en", 32'(fir_en), 32'(ph == 1));
      chk("underrun", 32'(underrun), 32'(uf_m));
`ifdef FIR_FEEDER_UNDERRUN_CNT_EN
      chk("underrun_cnt", 32'(underrun_cnt), 32'(cnt_m));
`endif
      if (fir_sample_in) chk("fir_din", 32'(fir_din), sz > 0 ? 32'(q[0]) : 32'd0);
    end
    if (!rst) begin
      q.delete();
      uf_m = 0;
      cnt_m = 0;
      ph = 0;
      mv = 1;
    end else if (mv) begin
      sz = q.size();
      if (clr) begin
        q.delete();
        uf_m = 0;
        cnt_m = 0;
      end else begin
        if (fir_sample_in && ph != 0) begin
          if (sz > 0) void'(q.pop_front());
          else begin
            uf_m = 1;
            if (cnt_m != 16'hFFFF) cnt_m++;
          end
        end
        if (s_valid && sz < DEPTH) q.push_back(s_data);
      end
      ph = ph == 0 ? (q.size() >= SL ? 1 : 0) : 2;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [15:0] d);
    int n = 0;
    s_valid = 1;
    s_data = d;
    while (!s_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL push_timeout actual=s_ready_low required=accept");
    end
    tick();
    s_valid = 0;
  endtask
  task automatic strobe(input int gap);
    fir_sample_in = 1;
    tick();
    fir_sample_in = 0;
    repeat (gap - 1) tick();
  endtask
  initial begin
    int nxt, guard;
    rst = 0; s_valid = 0; s_data = 0; clr = 0; fir_sample_in = 0;
    repeat (3) tick();
    rst = 1;
    for (int i = 1; i <= 4; i++) push(16'(i));
    repeat (5) tick();
    repeat (4) strobe(24);
    for (int i = 0; i < 8; i++) push(16'h7FFF - 16'(i));
    s_valid = 1; s_data = 16'h7FF7;
    repeat (3) tick();
    fir_sample_in = 1;
    tick();
    fir_sample_in = 0;
    tick();
    s_valid = 0;
    repeat (8) strobe(24);
    s_valid = 1; s_data = 16'h8000; fir_sample_in = 1;
    tick();
    s_valid = 0; fir_sample_in = 0;
    repeat (23) tick();
    strobe(24);
    clr = 1;
    tick();
    clr = 0;
    nxt = 100; guard = 0;
    while ((nxt < 120 || q.size() > 0) && guard < 3000) begin
      s_valid = nxt < 120 && q.size() < 7 && $urandom_range(0, 1) == 1;
      s_data = 16'(nxt);
      fir_sample_in = (q.size() >= 2 || (nxt >= 120 && q.size() > 0)) && $urandom_range(0, 2) == 0;
      if (s_valid) nxt++;
      tick();
      guard++;
    end
    s_valid = 0; fir_sample_in = 0;
    for (int i = 0; i < 400; i++) begin
      s_valid = $urandom_range(0, 2) != 0;
      s_data = 16'($urandom);
      fir_sample_in = $urandom_range(0, 3) == 0;
      clr = $urandom_range(0, 63) == 0;
      tick();
    end
    s_valid = 0; fir_sample_in = 0; clr = 0;
    clr = 1;
    tick();
    clr = 0;
    for (int i = 0; i < 5; i++) push(16'($urandom));
    repeat (2) tick();
    clr = 1;
    tick();
    clr = 0;
    repeat (3) tick();
    strobe(24);
    rst = 0;
    tick();
    rst = 1;
    for (int i = 0; i < 4; i++) push(16'($urandom));
    repeat (5) tick();
    repeat (5) strobe(24);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
